// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-through bypass
// and a per-register busy scoreboard with a running busy count.
module regfile_mp_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  logic set_v;
  logic clr_v;
  logic same;
  logic inc;
  logic dec;

  assign set_v = sb_set && (sb_addr != '0);
  assign clr_v = we && (wr_addr != '0);
  assign same  = set_v && clr_v && (sb_addr == wr_addr);

  // The count tracks the popcount of busy after the update:
  // a set on the retiring register keeps it busy, so no decrement.
  assign inc = set_v && !busy[sb_addr];
  assign dec = clr_v && busy[wr_addr] && !same;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (clr_v) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (set_v && sb_addr == AW'(r)) begin
          busy[r] <= 1'b1;
        end else if (clr_v && wr_addr == AW'(r)) begin
          busy[r] <= 1'b0;
        end
      end
      busy[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   busy_cnt <= busy_cnt + 1'b1;
        2'b01:   busy_cnt <= busy_cnt - 1'b1;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    logic          zero;

    assign a    = rd_addr[i*AW +: AW];
    assign zero = (a == '0);
    assign hit  = we && (wr_addr == a);

    assign rd_data[i*XLEN +: XLEN] = zero ? '0      :
                                     hit  ? wr_data :
                                            regs[a];
    assign rd_busy[i] = !zero && !hit && busy[a];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: storage, bypass,
// scoreboard set/clear priority and busy count.
module tb_regfile_mp_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  we;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  sb_set;
  logic [AW-1:0]         sb_addr;
  logic [AW:0]           busy_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  regfile_mp_sb #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NREAD(NREAD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  wire [XLEN-1:0] d0 = rd_data[0 +: XLEN];
  wire [XLEN-1:0] d1 = rd_data[XLEN +: XLEN];

  task automatic tick();
    @(posedge clk);
    #1;
    we     = 1'b0;
    sb_set = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    chk_cnt++;
    if (busy_cnt !== 6'd0) $display("FAIL rst_init_cnt got %0d exp 0", busy_cnt);
    else pass_cnt++;
    we = 1; wr_addr = 5; wr_data = 64'hDEAD;
    sb_set = 1; sb_addr = 11;
    tick();
    rd(5, 11);
    chk_cnt++;
    if (d0 !== 64'hDEAD) $display("FAIL pre_rst_data got %h exp dead", d0);
    else pass_cnt++;
    chk_cnt++;
    if (rd_busy !== 2'b10 || busy_cnt !== 6'd1)
      $display("FAIL pre_rst_busy got %b/%0d exp 10/1", rd_busy, busy_cnt);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (d0 !== 64'h0) $display("FAIL rst_async_data got %h exp 0", d0);
    else pass_cnt++;
    chk_cnt++;
    if (rd_busy !== 2'b00 || busy_cnt !== 6'd0)
      $display("FAIL rst_async_busy got %b/%0d exp 00/0", rd_busy, busy_cnt);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    we = 1; wr_addr = 3; wr_data = 64'h1234;
    tick();
    rd(3, 3);
    chk_cnt++;
    if (d0 !== 64'h1234 || d1 !== 64'h1234)
      $display("FAIL wr_rd got %h/%h exp 1234", d0, d1);
    else pass_cnt++;
    we = 1; wr_addr = 0; wr_data = 64'hFFFF;
    tick();
    rd(0, 3);
    chk_cnt++;
    if (d0 !== 64'h0 || rd_busy[0] !== 1'b0)
      $display("FAIL wr_zero got %h/%b exp 0/0", d0, rd_busy[0]);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    sb_set = 1; sb_addr = 7;
    tick();
    rd(3, 7);
    chk_cnt++;
    if (rd_busy[1] !== 1'b1 || busy_cnt !== 6'd1)
      $display("FAIL byp_pre got %b/%0d exp 1/1", rd_busy[1], busy_cnt);
    else pass_cnt++;
    we = 1; wr_addr = 7; wr_data = 64'hA5A5;
    #1;
    chk_cnt++;
    if (d1 !== 64'hA5A5 || rd_busy[1] !== 1'b0)
      $display("FAIL bypass got %h/%b exp a5a5/0", d1, rd_busy[1]);
    else pass_cnt++;
    chk_cnt++;
    if (d0 !== 64'h1234) $display("FAIL byp_other got %h exp 1234", d0);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (d1 !== 64'hA5A5 || busy_cnt !== 6'd0)
      $display("FAIL byp_post got %h/%0d exp a5a5/0", d1, busy_cnt);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    sb_set = 1; sb_addr = 9;
    tick();
    rd(9, 3);
    chk_cnt++;
    if (rd_busy !== 2'b01 || busy_cnt !== 6'd1)
      $display("FAIL sb_set got %b/%0d exp 01/1", rd_busy, busy_cnt);
    else pass_cnt++;
    we = 1; wr_addr = 9; wr_data = 64'h99;
    tick();
    chk_cnt++;
    if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || d0 !== 64'h99)
      $display("FAIL sb_clr got %b/%0d/%h exp 0/0/99", rd_busy[0], busy_cnt, d0);
    else pass_cnt++;
  endtask

  task automatic test_same_reg();
    sb_set = 1; sb_addr = 4;
    tick();
    sb_set = 1; sb_addr = 4;
    we = 1; wr_addr = 4; wr_data = 64'h44;
    tick();
    rd(4, 0);
    chk_cnt++;
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1 || d0 !== 64'h44)
      $display("FAIL same_reg got %b/%0d/%h exp 1/1/44", rd_busy[0], busy_cnt, d0);
    else pass_cnt++;
    sb_set = 1; sb_addr = 4;
    tick();
    chk_cnt++;
    if (busy_cnt !== 6'd1) $display("FAIL reset_busy got %0d exp 1", busy_cnt);
    else pass_cnt++;
    we = 1; wr_addr = 4; wr_data = 64'h45;
    tick();
    chk_cnt++;
    if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0)
      $display("FAIL same_clr got %0d/%b exp 0/0", busy_cnt, rd_busy[0]);
    else pass_cnt++;
    we = 1; wr_addr = 4; wr_data = 64'h46;
    tick();
    chk_cnt++;
    if (busy_cnt !== 6'd0 || d0 !== 64'h46)
      $display("FAIL clr_idle got %0d/%h exp 0/46", busy_cnt, d0);
    else pass_cnt++;
  endtask

  task automatic test_diff_reg();
    sb_set = 1; sb_addr = 2;
    tick();
    sb_set = 1; sb_addr = 6;
    we = 1; wr_addr = 2; wr_data = 64'h22;
    tick();
    rd(6, 2);
    chk_cnt++;
    if (rd_busy !== 2'b01 || busy_cnt !== 6'd1)
      $display("FAIL diff_reg got %b/%0d exp 01/1", rd_busy, busy_cnt);
    else pass_cnt++;
    sb_set = 1; sb_addr = 0;
    tick();
    rd(0, 6);
    chk_cnt++;
    if (rd_busy !== 2'b10 || busy_cnt !== 6'd1)
      $display("FAIL set_zero got %b/%0d exp 10/1", rd_busy, busy_cnt);
    else pass_cnt++;
    we = 1; wr_addr = 6; wr_data = 64'h66;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int r = 1; r < NREGS; r++) begin
      sb_set = 1; sb_addr = AW'(r);
      tick();
    end
    rd(31, 1);
    chk_cnt++;
    if (busy_cnt !== 6'd31 || rd_busy !== 2'b11)
      $display("FAIL b2b_full got %0d/%b exp 31/11", busy_cnt, rd_busy);
    else pass_cnt++;
    for (int r = 1; r < NREGS; r++) begin
      we = 1; wr_addr = AW'(r); wr_data = 64'(r * 3);
      tick();
    end
    rd(31, 1);
    chk_cnt++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00)
      $display("FAIL b2b_empty got %0d/%b exp 0/00", busy_cnt, rd_busy);
    else pass_cnt++;
    chk_cnt++;
    if (d0 !== 64'd93 || d1 !== 64'd3)
      $display("FAIL b2b_data got %0d/%0d exp 93/3", d0, d1);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    we = 0; wr_addr = '0; wr_data = '0;
    sb_set = 0; sb_addr = '0;
    #12 rst = 1'b0;
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_same_reg();
    test_diff_reg();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
